// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and byte-packing constants shared by the
// instruction-memory loader and its byte packer.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_IDX_W = $clog2(WORD_BYTES);
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// imem_loader_packer: assembles little-endian stream bytes into one word and
// flags the completed word for exactly one cycle.
module imem_loader_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              last_byte_c,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_IDX_W-1:0] byte_idx;

  assign last_byte_c = byte_valid && (byte_idx == BYTE_IDX_W'(WORD_BYTES - 1));

  // Shifting in from the top leaves the first byte in word[7:0] after four bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx  <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      byte_idx  <= '0;
      word_full <= 1'b0;
    end else begin
      word_full <= last_byte_c;
      if (byte_valid) begin
        word     <= {byte_in, word[WORD_W-1:8]};
        byte_idx <= byte_idx + BYTE_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer that streams a length-prefixed image into the
// instruction memory and holds the core in reset until it is loaded.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] hdr_len;
  logic [CNT_W-1:0] wl_next;
  logic             accept;
  logic             load_start;
  logic             data_byte;
  logic             last_byte_c;
  logic [WORD_W-1:0] word;

  assign accept     = in_valid && in_ready;
  assign load_start = start && (state inside {IDLE, DONE, ERROR});
  assign data_byte  = accept && (state == DATA);
  assign hdr_len    = CNT_W'({in_data, len[7:0]});
  assign wl_next    = words_loaded + CNT_W'(1);
  assign imem_wdata = word;

  // The packer's registered word_full pulse lands exactly in the WRITE cycle.
  imem_loader_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (load_start),
    .byte_valid  (data_byte),
    .byte_in     (in_data),
    .last_byte_c (last_byte_c),
    .word_full   (imem_we),
    .word        (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (reset || load_start) begin
      csum <= '0;
    end else if (data_byte) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      in_ready     <= 1'b0;
      imem_addr    <= BASE_ADDR;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            imem_addr    <= BASE_ADDR;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len <= hdr_len;
            if (hdr_len == '0) begin
              state     <= CSUM_EN ? CSUM : DONE;
              in_ready  <= CSUM_EN;
              busy      <= CSUM_EN;
              done      <= !CSUM_EN;
              core_hold <= CSUM_EN;
            end else if (hdr_len > CNT_W'(DEPTH)) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (last_byte_c) begin
            state    <= WRITE;
            in_ready <= 1'b0;
          end
        end
        WRITE: begin
          words_loaded <= wl_next;
          imem_addr    <= imem_addr + 32'd4;
          if (wl_next == len) begin
            state     <= CSUM_EN ? CSUM : DONE;
            in_ready  <= CSUM_EN;
            busy      <= CSUM_EN;
            done      <= !CSUM_EN;
            core_hold <= CSUM_EN;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= ERROR;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end

endmodule
